// File: rtl/frq_edge_meter_if.sv
// Control/result bundle between a measurement client and frq_edge_meter.
// The client drives the request side; the meter drives the result side.
interface frq_edge_meter_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       gate_sel;
    logic             start;
    logic             continuous;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output gate_sel, start, continuous,
        input  count_out, count_valid, overflow, busy
    );

    modport slave (
        input  gate_sel, start, continuous,
        output count_out, count_valid, overflow, busy
    );
endinterface

// File: rtl/frq_edge_meter.sv
// Gated frequency meter: counts synchronized rising edges of the divided clock
// over a 2^(8+gate_sel) cycle window and publishes the count with a valid strobe.
//
// state | meaning
// IDLE  | waiting for start or continuous
// GATE  | window open, gate counter running, rises counted
// DONE  | one-cycle result slot, count_valid high
module frq_edge_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_in,
    frq_edge_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     history_q;
    logic                     rise;
    logic [GATE_W-1:0]        gate_cnt;
    logic [CNT_W-1:0]         edge_cnt;
    logic [CNT_W-1:0]         edge_next;
    logic                     ovf_flag;
    logic                     ovf_next;
    logic                     sat;
    logic [CNT_W-1:0]         count_out_q;
    logic                     count_valid_q;
    logic                     overflow_q;
    logic                     busy_q;

    // Window length minus one, since the terminal cycle is the one seeing zero.
    function automatic logic [GATE_W-1:0] gate_load(input logic [2:0] sel);
        logic [31:0] n;
        n = 32'd1 << (32'd8 + 32'(sel));
        return GATE_W'(n - 32'd1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            history_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            history_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise      = sync_q[SYNC_STAGES-1] & ~history_q;
    assign sat       = &edge_cnt;
    assign edge_next = (rise && !sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign ovf_next  = ovf_flag | (rise & sat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            gate_cnt      <= '0;
            edge_cnt      <= '0;
            ovf_flag      <= 1'b0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        state    <= GATE;
                        gate_cnt <= gate_load(bus.gate_sel);
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                GATE: begin
                    edge_cnt <= edge_next;
                    ovf_flag <= ovf_next;
                    // Publish on the terminal edge so the result is visible during DONE,
                    // including any rise that lands in the last window cycle.
                    if (gate_cnt == '0) begin
                        state         <= DONE;
                        count_out_q   <= edge_next;
                        overflow_q    <= ovf_next;
                        count_valid_q <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                DONE: begin
                    if (bus.continuous) begin
                        state    <= GATE;
                        gate_cnt <= gate_load(bus.gate_sel);
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_out   = count_out_q;
    assign bus.count_valid = count_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = busy_q;

endmodule
